// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder slice with a registered carry,
// consuming operands LSB-first over WIDTH cycles after an accepted start.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// ADD   | one operand bit pair summed per clock (busy=1)
// DONE  | single-cycle done pulse, sum/carry_out valid
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a, b, r;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s, cout, last_bit;

  assign s        = a[0] ^ b[0] ^ c;
  assign cout     = (a[0] & b[0]) | (c & (a[0] ^ b[0]));
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ADD;
      ADD: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      r         <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a   <= ip1;
            b   <= ip2;
            c   <= 1'b0;
            cnt <= '0;
          end
        end
        ADD: begin
          a   <= a >> 1;
          b   <= b >> 1;
          r   <= {s, r[WIDTH-1:1]};
          c   <= cout;
          cnt <= cnt + CW'(1);
          // the final bit goes straight to the output, bypassing r
          if (last_bit) begin
            sum       <= {s, r[WIDTH-1:1]};
            carry_out <= cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8: latency, results,
// ignored mid-ADD starts, back-to-back starts and mid-operation reset.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] ip1, ip2;
  logic             busy, done, carry_out;
  logic [WIDTH-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .ip1(ip1), .ip2(ip2),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one complete operation; returns at the negedge where done is high
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [WIDTH:0] exp, input string tag);
    int  bc;
    bit  seen;
    @(negedge clk);
    ip1 = x; ip2 = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) bc++;
        @(negedge clk);
      end
    end
    check({tag, " done_seen"}, 33'(seen), 33'd1);
    check({tag, " busy_cycles"}, 33'(bc), 33'(WIDTH));
    check({tag, " busy_at_done"}, 33'(busy), 33'd0);
    check({tag, " result"}, 33'({carry_out, sum}), 33'(exp));
  endtask

  initial begin
    int cyc, last, pulses, dcount;
    bit seen;
    rst = 1'b1; start = 1'b0; ip1 = '0; ip2 = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 33'(busy), 33'd0);
    check("rst done", 33'(done), 33'd0);
    check("rst sum", 33'(sum), 33'd0);
    check("rst carry", 33'(carry_out), 33'd0);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 9'h008, "05+03");
    run_op(8'hFF, 8'h01, 9'h100, "FF+01");
    run_op(8'h00, 8'h00, 9'h000, "00+00");
    run_op(8'hFF, 8'hFF, 9'h1FE, "FF+FF");

    // second start during ADD must be ignored and not queued
    @(negedge clk);
    ip1 = 8'h10; ip2 = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid held", 33'({carry_out, sum}), 33'h1FE);
    ip1 = 8'hAA; ip2 = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid held2", 33'({carry_out, sum}), 33'h1FE);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("mid done_seen", 33'(seen), 33'd1);
    check("mid result", 33'({carry_out, sum}), 33'h030);
    @(negedge clk);
    check("mid no_queue busy", 33'(busy), 33'd0);
    @(negedge clk);
    check("mid no_queue busy2", 33'(busy), 33'd0);

    // start held high: one result every WIDTH+2 cycles
    ip1 = 8'h80; ip2 = 8'h80; start = 1'b1;
    cyc = 0; last = -1; pulses = 0;
    for (int i = 0; i < 60 && pulses < 3; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        pulses++;
        check("b2b result", 33'({carry_out, sum}), 33'h100);
        check("b2b busy_at_done", 33'(busy), 33'd0);
        if (last >= 0) check("b2b period", 33'(cyc - last), 33'(WIDTH + 2));
        last = cyc;
      end
    end
    start = 1'b0;
    check("b2b pulses", 33'(pulses), 33'd3);

    // reset in the middle of an operation
    run_op(8'h05, 8'h03, 9'h008, "pre-rst");
    @(negedge clk);
    ip1 = 8'hFF; ip2 = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst mid busy_before", 33'(busy), 33'd1);
    #2 rst = 1'b1;
    #1;
    check("rst mid busy", 33'(busy), 33'd0);
    check("rst mid done", 33'(done), 33'd0);
    check("rst mid sum", 33'(sum), 33'd0);
    check("rst mid carry", 33'(carry_out), 33'd0);
    dcount = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dcount++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("rst mid no_done", 33'(dcount), 33'd0);
    run_op(8'h12, 8'h34, 9'h046, "post-rst");

    for (int k = 0; k < 150; k++) begin
      logic [WIDTH-1:0] x, y;
      x = WIDTH'($urandom_range(0, 255));
      y = WIDTH'($urandom_range(0, 255));
      run_op(x, y, {1'b0, x} + {1'b0, y}, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
